// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Debounces the synchronized active-low push-button lines and classifies each
// press as short or long. Every channel is independent; all channels share one
// tick prescaler that also drives the exported Tick strobe.
//
// Ports:
//   Clock       in   system clock (single domain)
//   Reset       in   asynchronous, active-high reset
//   nButton     in   [NUM_BUTTONS] synchronized raw buttons, 0 = pressed
//   Held        out  [NUM_BUTTONS] debounced level, 1 = pressed
//   ShortPress  out  [NUM_BUTTONS] 1-cycle pulse on release of a short press
//   LongPress   out  [NUM_BUTTONS] 1-cycle pulse when a press reaches LONG_TICKS
//   Repeat      out  [NUM_BUTTONS] 1-cycle auto-repeat pulse while long-held
//   Tick        out  1-cycle prescaler tick (registered)
//
// Optional feature macro: BUTTON_AUTO_REPEAT_EN
//   defined   -> Repeat pulses every REPEAT_TICKS ticks while in LONG
//   undefined -> Repeat tied to 0, no repeat counters built
//
// Event pulses and Held leave through the same number of register stages, so
// a ShortPress lines up with the falling edge of Held.
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int NUM_BUTTONS    = 2,
    parameter int TICK_DIV       = 32,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 1024,
    parameter int REPEAT_TICKS   = 256
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [NUM_BUTTONS-1:0] nButton,
    output logic [NUM_BUTTONS-1:0] Held,
    output logic [NUM_BUTTONS-1:0] ShortPress,
    output logic [NUM_BUTTONS-1:0] LongPress,
    output logic [NUM_BUTTONS-1:0] Repeat,
    output logic                   Tick
);

    localparam int TICK_W = (TICK_DIV > 1)       ? $clog2(TICK_DIV)       : 1;
    localparam int DB_W   = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam int HOLD_W = (LONG_TICKS > 1)     ? $clog2(LONG_TICKS)     : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);

    if (TICK_DIV < 2 || DEBOUNCE_TICKS < 2 || LONG_TICKS < 2 ||
        REPEAT_TICKS < 1 || NUM_BUTTONS < 1) begin : gBadParams
        $error("button_conditioner: TICK_DIV, DEBOUNCE_TICKS, LONG_TICKS must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } chanState_t;

    // ---------------- shared prescaler ----------------
    logic [TICK_W-1:0] tickCount;
    logic              tickInt;

    assign tickInt = (tickCount == TICK_LAST);

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            tickCount <= '0;
            Tick      <= 1'b0;
        end else begin
            tickCount <= tickInt ? '0 : tickCount + 1'b1;
            Tick      <= tickInt;
        end
    end

    // ---------------- per-channel logic ----------------
    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : gChan
        logic              raw;
        logic              stable;
        logic [DB_W-1:0]   dbCount;
        logic              accept;
        logic              acceptRise;
        logic              acceptFall;
        chanState_t        state;
        chanState_t        stateNext;
        logic [HOLD_W-1:0] holdCount;
        logic [HOLD_W-1:0] holdNext;
        logic              shortNext;
        logic              longNext;
        logic              shortEvt;
        logic              longEvt;
        logic              heldQ;
        logic              shortQ;
        logic              longQ;

        assign raw        = ~nButton[i];
        // A change is accepted on the tick that completes DEBOUNCE_TICKS
        // consecutive ticks of a differing level.
        assign accept     = tickInt && (raw != stable) && (dbCount == DB_LAST);
        assign acceptRise = accept && raw;
        assign acceptFall = accept && !raw;

        // The count clears on any clock where the input agrees with the
        // stable level, so a glitch never accumulates across bounces.
        always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
                stable  <= 1'b0;
                dbCount <= '0;
            end else if (raw == stable) begin
                dbCount <= '0;
            end else if (tickInt) begin
                if (dbCount == DB_LAST) begin
                    stable  <= raw;
                    dbCount <= '0;
                end else begin
                    dbCount <= dbCount + 1'b1;
                end
            end
        end

`ifdef BUTTON_AUTO_REPEAT_EN
        localparam int             REP_W    = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
        localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);
        logic [REP_W-1:0] repCount;
        logic [REP_W-1:0] repCountNext;
        logic             repeatNext;
        logic             repeatEvt;
        logic             repeatQ;
`endif

        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        always_comb begin
            stateNext = state;
            holdNext  = holdCount;
            shortNext = 1'b0;
            longNext  = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
            repCountNext = repCount;
            repeatNext   = 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (acceptRise) begin
                        stateNext = PRESSED;
                        holdNext  = '0;
                    end
                end
                PRESSED: begin
                    // Release is checked first so it wins over a same-tick
                    // long threshold.
                    if (acceptFall) begin
                        stateNext = IDLE;
                        shortNext = 1'b1;
                    end else if (tickInt) begin
                        if (holdCount == HOLD_LAST) begin
                            stateNext = LONG;
                            longNext  = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
                            repCountNext = '0;
`endif
                        end else begin
                            // Stops at HOLD_LAST, so it saturates rather than wraps.
                            holdNext = holdCount + 1'b1;
                        end
                    end
                end
                LONG: begin
                    if (acceptFall) begin
                        stateNext = IDLE;
                    end
`ifdef BUTTON_AUTO_REPEAT_EN
                    else if (tickInt) begin
                        if (repCount == REP_LAST) begin
                            repeatNext   = 1'b1;
                            repCountNext = '0;
                        end else begin
                            repCountNext = repCount + 1'b1;
                        end
                    end
`endif
                end
                default: stateNext = IDLE;
            endcase
        end

        // NOTE: reset clears every flop, including the event pipeline, so a
        // press interrupted by reset can never leak a pulse afterwards.
        always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
                state     <= IDLE;
                holdCount <= '0;
                shortEvt  <= 1'b0;
                longEvt   <= 1'b0;
                heldQ     <= 1'b0;
                shortQ    <= 1'b0;
                longQ     <= 1'b0;
            end else begin
                state     <= stateNext;
                holdCount <= holdNext;
                shortEvt  <= shortNext;
                longEvt   <= longNext;
                heldQ     <= stable;
                shortQ    <= shortEvt;
                longQ     <= longEvt;
            end
        end

        assign Held[i]       = heldQ;
        assign ShortPress[i] = shortQ;
        assign LongPress[i]  = longQ;

`ifdef BUTTON_AUTO_REPEAT_EN
        always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
                repCount  <= '0;
                repeatEvt <= 1'b0;
                repeatQ   <= 1'b0;
            end else begin
                repCount  <= repCountNext;
                repeatEvt <= repeatNext;
                repeatQ   <= repeatEvt;
            end
        end

        assign Repeat[i] = repeatQ;
`else
        assign Repeat[i] = 1'b0;
`endif
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Sits directly downstream of the pad-ring two-flop synchronizers and upstream of the computer core.
- Takes the synchronized, active-low push-button lines (nMode, nTrip) and debounces each one.
- Classifies every press as short or long and delivers one-cycle event pulses plus a clean held level to the core's mode/trip logic.
- Independent per-button channels share one tick prescaler.

Parameters:
NUM_BUTTONS, 2, number of independent button channels (bit 0 = Mode, bit 1 = Trip)
TICK_DIV, 32, clock cycles per debounce/timing tick (32768 Hz clock -> 1.024 kHz tick)
DEBOUNCE_TICKS, 20, consecutive ticks of a stable differing level needed to accept a change
LONG_TICKS, 1024, ticks a debounced press must last to count as long
REPEAT_TICKS, 256, auto-repeat interval in ticks (used only with the optional feature)

Ports:
Clock  input  1  system clock; one clock domain
Reset  input  1  asynchronous, active-high reset
nButton  input  NUM_BUTTONS  synchronized raw buttons, active low (0 = pressed)
Held  output  NUM_BUTTONS  debounced level, 1 = pressed
ShortPress  output  NUM_BUTTONS  1-cycle pulse on release of a press shorter than LONG_TICKS
LongPress  output  NUM_BUTTONS  1-cycle pulse when a press reaches LONG_TICKS
Repeat  output  NUM_BUTTONS  1-cycle auto-repeat pulse while long-held
Tick  output  1  1-cycle prescaler tick, exported for core timebases

Behaviour:
- Interface: one clock (Clock). Reset is asynchronous and active-high.
- Reset values:
  - All outputs 0.
  - Prescaler 0.
  - All debounce counters, hold counters and repeat counters 0.
  - Stable level = released.
  - Every channel state = IDLE.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - Internal tick is true in the cycle where count == TICK_DIV-1.
  - Tick output is that value registered, so it lags by 1 cycle.
- Debounce, per channel. Let raw = ~nButton[i].
  - If raw == stable: debounce count clears to 0 on every clock, not only on ticks.
  - If raw != stable: count increments on each tick.
  - When a tick arrives with count == DEBOUNCE_TICKS-1: stable <= raw and count <= 0.
  - A glitch shorter than DEBOUNCE_TICKS ticks never changes stable.
  - Held = stable, registered.
- Per-channel FSM: IDLE, PRESSED, LONG.
  - IDLE -> PRESSED when stable goes 0->1; hold count <= 0.
  - In PRESSED, hold count increments on each tick.
  - PRESSED -> LONG on the tick where hold count == LONG_TICKS-1; LongPress[i] = 1 for the next cycle only.
  - PRESSED -> IDLE when stable goes 1->0; ShortPress[i] = 1 for the next cycle only.
  - LONG -> IDLE when stable goes 1->0; no ShortPress.
  - Hold count saturates and never wraps.
- Latency:
  - Event pulses are registered and appear exactly 1 clock after the stable/FSM transition.
  - Press-to-Held latency is DEBOUNCE_TICKS ticks plus 0..TICK_DIV-1 cycles of prescaler phase, plus 1 clock.
- Simultaneous events:
  - Channels are fully independent; several channels may pulse in the same cycle.
  - If a release is accepted in the same tick where the hold count reaches LONG_TICKS-1, the release wins: ShortPress fires, LongPress does not.
- Reset mid-operation:
  - Aborts any press with no pulse emitted.
  - A button held through reset deassertion is debounced afresh from released and produces a normal press sequence.
- Widths:
  - Each counter is $clog2 of its parameter, minimum 1 bit.
  - DEBOUNCE_TICKS, LONG_TICKS and TICK_DIV must all be >= 2. Enforced by an elaboration-time check.

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- Defined:
  - In state LONG, a per-channel repeat counter increments on each tick.
  - On the tick where it reaches REPEAT_TICKS-1, Repeat[i] pulses for 1 cycle and the counter clears.
  - Counter clears on entry to LONG, so the first Repeat comes REPEAT_TICKS ticks after LongPress.
  - Release stops repeats immediately.
- Undefined: Repeat is tied to 0 and no repeat counters are built.

Test Plan:
All scenarios use TICK_DIV=4, DEBOUNCE_TICKS=3, LONG_TICKS=10, REPEAT_TICKS=4.
1. Reset asserted mid-cycle with nButton=2'b00 -> all outputs 0 immediately (async). After release, Held=2'b11 within 3 ticks (<=13 cycles) and no ShortPress/LongPress.
2. nButton[0] low for 20 cycles (5 ticks) then high -> Held[0] rises. On release, after the 3-tick debounce, ShortPress[0]=1 for exactly 1 cycle. LongPress[0] never asserts.
3. nButton[1] low for 2 ticks (8 cycles) then high -> Held[1] stays 0 and no pulses at all.
4. nButton[0] held low for 60 cycles -> LongPress[0] is a single 1-cycle pulse exactly 10 ticks after Held[0] rose. Release gives no ShortPress.
5. Both buttons pressed on the same cycle for 5 ticks, then released together -> ShortPress=2'b11 in the same cycle.
6. With BUTTON_AUTO_REPEAT_EN, hold nButton[0] low for 30 ticks -> Repeat[0] pulses every 4 ticks after LongPress, 4 pulses total before release (first 4 ticks after LongPress). Without the macro, Repeat stays 0 throughout.
